// File: rtl/drum_mem_pkg.sv
// Shared types for the drum memory unit: FSM states, operation codes and the request record.
// Request fields are sized for the widest supported configuration; the top slices them down.
package drum_mem_pkg;

  localparam int REQ_ADDR_W = 16;
  localparam int REQ_DATA_W = 32;

  typedef enum logic [1:0] {IDLE, SEEK, XFER} state_e;
  typedef enum logic {OP_READ, OP_WRITE} op_e;

  typedef struct packed {
    op_e                   op;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] data;
  } req_t;

endpackage

// File: rtl/drum_mem_unit_position.sv
// Drum rotation model: phase within the current cell and the sector under the head.
// cell_end marks the last clock of a cell, the only clock on which a transfer may happen.
module drum_position
  import drum_mem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int CELL_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] sector,
  output logic              cell_end
);

  localparam int PH_W = $clog2(CELL_CYCLES);

  logic [PH_W-1:0] phase;

  assign cell_end = (phase == PH_W'(CELL_CYCLES - 1));

  // Sector wraps naturally at 2**ADDR_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase  <= '0;
      sector <= '0;
    end else if (cell_end) begin
      phase  <= '0;
      sector <= sector + 1'b1;
    end else begin
      phase  <= phase + 1'b1;
    end
  end

endmodule

// File: rtl/drum_mem_unit.sv
// Drum memory with rotational-latency access sequencer and a one-entry pending slot.
// Requests are served strictly in arrival order; data is transferred on the last clock of the addressed cell.
module drum_mem_unit
  import drum_mem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 31,
  parameter int CELL_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read_from_pu,
  input  logic [ADDR_W-1:0] addr_from_sel,
  input  logic              mem_write_from_ac,
  input  logic [DATA_W-1:0] data_from_ac,
  output logic              mem_read_reply_to_pu,
  output logic [DATA_W-1:0] data_to_ac,
  output logic              mem_write_done_to_ac,
  output logic              busy_to_io,
  output logic              overrun_to_io,
  output logic [ADDR_W-1:0] drum_sector_to_io
);

  localparam int CELLS = 2 ** ADDR_W;

  state_e            state, state_nxt;
  req_t              cur, cur_nxt, slot, slot_nxt;
  logic              slot_vld, slot_vld_nxt, slot_free, ovr_set;
  logic [ADDR_W-1:0] sector;
  logic              cell_end, match;
  req_t              rd_req, wr_req;
  logic [DATA_W-1:0] mem [CELLS];
  logic              unused_data_bits;

  drum_position #(.ADDR_W(ADDR_W), .CELL_CYCLES(CELL_CYCLES)) u_pos (
    .clk      (clk),
    .reset    (reset),
    .sector   (sector),
    .cell_end (cell_end)
  );

  assign rd_req = '{op: OP_READ,  addr: REQ_ADDR_W'(addr_from_sel), data: '0};
  assign wr_req = '{op: OP_WRITE, addr: REQ_ADDR_W'(addr_from_sel), data: REQ_DATA_W'(data_from_ac)};

  assign match             = (state == SEEK) && cell_end && (cur.addr == REQ_ADDR_W'(sector));
  assign busy_to_io        = (state != IDLE) || slot_vld;
  assign drum_sector_to_io = sector;
  assign unused_data_bits  = ^cur.data;

  always_comb begin
    state_nxt            = state;
    cur_nxt              = cur;
    slot_nxt             = slot;
    slot_vld_nxt         = slot_vld;
    slot_free            = !slot_vld;
    ovr_set              = 1'b0;
    mem_read_reply_to_pu = 1'b0;
    mem_write_done_to_ac = 1'b0;

    // Anything not taken directly by IDLE competes for the slot; read ahead of write.
    if (mem_read_from_pu && state != IDLE) begin
      if (slot_free) begin
        slot_nxt     = rd_req;
        slot_vld_nxt = 1'b1;
        slot_free    = 1'b0;
      end else begin
        ovr_set = 1'b1;
      end
    end
    if (mem_write_from_ac && (state != IDLE || mem_read_from_pu)) begin
      if (slot_free) begin
        slot_nxt     = wr_req;
        slot_vld_nxt = 1'b1;
        slot_free    = 1'b0;
      end else begin
        ovr_set = 1'b1;
      end
    end

    case (state)
      IDLE: begin
        if (mem_read_from_pu) begin
          cur_nxt   = rd_req;
          state_nxt = SEEK;
        end else if (mem_write_from_ac) begin
          cur_nxt   = wr_req;
          state_nxt = SEEK;
        end
      end
      SEEK: if (match) state_nxt = XFER;
      XFER: begin
        if (cur.op == OP_READ) mem_read_reply_to_pu = 1'b1;
        else                   mem_write_done_to_ac = 1'b1;
        // An entry arriving this very clock into an empty slot is promoted straight to service.
        if (slot_vld) begin
          cur_nxt      = slot;
          slot_vld_nxt = 1'b0;
          state_nxt    = SEEK;
        end else if (slot_vld_nxt) begin
          cur_nxt      = slot_nxt;
          slot_vld_nxt = 1'b0;
          state_nxt    = SEEK;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cur           <= '0;
      slot          <= '0;
      slot_vld      <= 1'b0;
      overrun_to_io <= 1'b0;
      data_to_ac    <= '0;
    end else begin
      state         <= state_nxt;
      cur           <= cur_nxt;
      slot          <= slot_nxt;
      slot_vld      <= slot_vld_nxt;
      overrun_to_io <= overrun_to_io | ovr_set;
      if (match && cur.op == OP_READ) data_to_ac <= mem[cur.addr[ADDR_W-1:0]];
    end
  end

  // Contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset && match && cur.op == OP_WRITE) mem[cur.addr[ADDR_W-1:0]] <= cur.data[DATA_W-1:0];
  end

endmodule
